// File: rtl/sum_result_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_result_pkg
// Brief    : Shared widths and result-word type for the adder result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package sum_result_pkg;

   localparam int SUM_W    = 4;
   localparam int RESULT_W = SUM_W + 1;

   typedef struct packed {
      logic             carry;
      logic [SUM_W-1:0] sum;
   } sum_word_t;

   // Builds the {carry, sum} word the adder hands to the FIFO.
   function automatic sum_word_t pack_result(input logic carry, input logic [SUM_W-1:0] sum);
      sum_word_t w;
      w.carry = carry;
      w.sum   = sum;
      return w;
   endfunction

endpackage : sum_result_pkg
`default_nettype wire

// File: rtl/sum_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sum_result_fifo
// Brief    : Valid/ready FIFO buffering {carry, sum} adder results for the
//            slower pin/display consumer. Optional drop counter enabled by
//            defining SUM_RESULT_FIFO_DROP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sum_result_fifo
   import sum_result_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = RESULT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic [3:0]               drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             w_push;
   logic             w_pop;

   // Flags depend only on the registered count, never on in_valid/out_ready.
   assign in_ready  = (count_q != C_FULL_CNT);
   assign out_valid = (count_q != '0);

   assign w_push = in_valid && in_ready;
   assign w_pop  = out_valid && out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + C_CNT_ONE;
         2'b01:   count_d = count_q - C_CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the reset cycle must not write a word.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
   assign count    = count_q;

`ifdef SUM_RESULT_FIFO_DROP_CNT_EN
   logic [3:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (in_valid && !in_ready && (drop_q != 4'hF)) begin
         drop_d = drop_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= 4'd0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = drop_q;
`else
   assign drop_cnt = 4'd0;
`endif

endmodule : sum_result_fifo
`default_nettype wire

// File: tb/tb_sum_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_result_fifo
// Brief    : Self-checking bench for sum_result_fifo with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_result_fifo;

   localparam int DEPTH = 4;
   localparam int WIDTH = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [2:0]       count;
   logic [3:0]       drop_cnt;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] mq[$];
   int               mdrop = 0;

   sum_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] exp_drop();
`ifdef SUM_RESULT_FIFO_DROP_CNT_EN
      return 4'(mdrop);
`else
      return 4'd0;
`endif
   endfunction

   function automatic logic [WIDTH-1:0] exp_head();
      return (mq.size() != 0) ? mq[0] : '0;
   endfunction

   // One clock edge: the model follows the FIFO rules, then outputs settle.
   task automatic tick();
      bit               acc;
      bit               pop;
      bit               drop;
      logic [WIDTH-1:0] d;
      acc  = in_valid && (mq.size() < DEPTH);
      pop  = out_ready && (mq.size() > 0);
      drop = in_valid && (mq.size() == DEPTH);
      d    = in_data;
      @(posedge clk);
      #1;
      if (rst) begin
         mq.delete();
         mdrop = 0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back(d);
         if (drop && mdrop < 15) mdrop++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 5'h1F; out_ready = 1'b1;
      tick();
      tick();
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_data !== 5'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
      checks++; if (drop_cnt !== 4'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      tick();
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_data = 5'b1_0011;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 5'h13) begin failures++; $display("FAIL single_data got=%h exp=13", out_data); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", count); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_fill_overflow();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_data = 5'(i);
         tick();
      end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
      for (int i = 0; i < 3; i++) begin
         in_data = 5'h1F;
         tick();
      end
      in_valid = 1'b0;
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL overflow_count got=%0d exp=4", count); end
      checks++; if (drop_cnt !== exp_drop()) begin failures++; $display("FAIL overflow_drop got=%0d exp=%0d", drop_cnt, exp_drop()); end
`ifdef SUM_RESULT_FIFO_DROP_CNT_EN
      checks++; if (drop_cnt !== 4'd3) begin failures++; $display("FAIL overflow_drop3 got=%0d exp=3", drop_cnt); end
`endif
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         checks++; if (out_data !== 5'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, out_data, 5'(i)); end
         tick();
      end
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_full_simul();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 5'(8'h0A + i);
         tick();
      end
      in_data = 5'h0E; out_ready = 1'b1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL simul_in_ready got=%b exp=0", in_ready); end
      tick();
      checks++; if (count !== 3'd3) begin failures++; $display("FAIL simul_count got=%0d exp=3", count); end
      checks++; if (out_data !== 5'h0B) begin failures++; $display("FAIL simul_head got=%h exp=0B", out_data); end
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL simul_refill got=%0d exp=4", count); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_data !== 5'(8'h0B + i)) begin failures++; $display("FAIL simul_drain[%0d] got=%h exp=%h", i, out_data, 5'(8'h0B + i)); end
         tick();
      end
      out_ready = 1'b0;
      checks++; if (drop_cnt !== exp_drop()) begin failures++; $display("FAIL simul_drop got=%0d exp=%0d", drop_cnt, exp_drop()); end
   endtask

   task automatic test_wrap();
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 5'(i);
         tick();
         checks++; if (count !== 3'd1) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=1", i, count); end
         checks++; if (out_data !== 5'(i)) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, out_data, 5'(i)); end
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_end got=%b exp=0", out_valid); end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 5'(8'h15 + i);
         tick();
      end
      rst = 1'b1; in_data = 5'h1A; out_ready = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", count); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
      checks++; if (drop_cnt !== 4'd0) begin failures++; $display("FAIL midrst_drop got=%0d exp=0", drop_cnt); end
      tick();
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL midrst_after got=%0d exp=0", count); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 59) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) == 0);
         in_data   = 5'($urandom);
         tick();
         checks++;
         if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) ||
             in_ready !== (mq.size() != DEPTH) || out_data !== exp_head() ||
             drop_cnt !== exp_drop()) begin
            failures++;
            $display("FAIL random[%0d] got cnt=%0d ov=%b ir=%b od=%h drop=%0d exp cnt=%0d od=%h drop=%0d",
                     n, count, out_valid, in_ready, out_data, drop_cnt, mq.size(), exp_head(), exp_drop());
         end
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #1;
      test_reset();
      test_single();
      test_fill_overflow();
      test_full_simul();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sum_result_fifo
`default_nettype wire

// File: doc/sum_result_fifo.md
Name: sum_result_fifo

Overview:
- Downstream stage of the 4-bit ripple-carry adder.
- Captures each 5-bit adder result ({carry_out, sum[3:0]}) under a valid/ready handshake and buffers it in a small FIFO.
- Presents results in order to the output pin stage through a second valid/ready handshake.
- Decouples adder evaluation from the slower consumer (pin sampling / display logic) inside the tt_um top.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- WIDTH, 5, result word width: bit 4 = carry_out, bits 3:0 = sum.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  adder result on in_data is valid this cycle.
- in_data  input  WIDTH  adder result {carry_out, sum}.
- in_ready  output  1  FIFO can accept a word this cycle.
- out_valid  output  1  out_data holds the oldest stored word.
- out_data  output  WIDTH  head-of-FIFO word.
- out_ready  input  1  consumer takes the head word this cycle.
- count  output  $clog2(DEPTH)+1  number of stored words.
- drop_cnt  output  4  attempted pushes while full (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled only at the rising edge of clk.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - out_valid = 0, in_ready = 1, out_data = 0, drop_cnt = 0.
  - Storage contents are don't-care.
- Push occurs when in_valid && in_ready at a rising edge. in_data is written to mem[wr_ptr], and wr_ptr increments modulo DEPTH.
- Pop occurs when out_valid && out_ready at a rising edge, and rd_ptr increments modulo DEPTH.
- Flag derivation:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - Both are derived from registered count only; no combinational path from in_valid or out_ready.
- out_data = mem[rd_ptr] when out_valid; 0 when empty.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N; first-word latency is 1 cycle. No bypass.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Boundary conditions:
  - Full: in_ready = 0. in_valid is ignored and no overwrite occurs. A simultaneous pop in the same cycle frees a slot; the push is accepted on the next cycle.
  - Empty: out_valid = 0. out_ready is ignored. A simultaneous push fills the slot but no pop occurs.
  - Pointer wrap: DEPTH-1 → 0, with no bubble.
- Reset mid-operation discards all contents. in_valid/out_ready in the reset cycle have no effect.
- Data integrity: order is preserved exactly. The carry bit travels with its sum; there is no modification of data.

Optional Feature:
- Macro: SUM_RESULT_FIFO_DROP_CNT_EN.
- Defined: drop_cnt increments on every rising edge where in_valid && !in_ready. It saturates at 15 and is cleared only by rst.
- Undefined: the drop counter logic is omitted and drop_cnt is tied to 0. The port is kept so the top-level wiring is identical.

Decomposition:
- Package sum_result_pkg:
  - SUM_W = 4.
  - RESULT_W = 5.
  - typedef packed struct sum_word_t {logic carry; logic [3:0] sum;}.
- Single module with no sub-module; storage is an inline register array.
- The pointer/count logic is small enough to stay local.

Test Plan:
- Reset then idle: rst high 2 cycles → count = 0, out_valid = 0, in_ready = 1, out_data = 0, drop_cnt = 0.
- Single push/pop: push 5'b1_0011 (carry 1, sum 3) → next cycle out_valid = 1, out_data = 5'h13, count = 1. Pop → count = 0, out_valid = 0.
- Fill and overflow: push 0x01, 0x02, 0x03, 0x04 with out_ready = 0 → in_ready = 0, count = 4. Three more in_valid cycles → data unchanged; drop_cnt = 3 with SUM_RESULT_FIFO_DROP_CNT_EN, else 0. Drain yields 0x01..0x04 in order.
- Full, simultaneous in_valid and pop: FIFO full, in_valid = 1, out_ready = 1 → head popped, push refused this cycle. Next cycle push accepted; count returns to 4.
- Wrap-around streaming: in_valid = out_ready = 1 for 10 cycles with incrementing data 0x00..0x09 → count stays 1 after the first cycle; outputs 0x00..0x09 in order across pointer wrap.
- Reset mid-operation: 3 words stored, assert rst for 1 cycle with in_valid = 1 → count = 0, out_valid = 0. The pushed word is not stored.
